// File: rtl/bigmem.sv
// Shared word-addressed data memory plus MEM/WB register for NPORT cores.
// Define BIGMEM_BYPASS_EN to forward same-cycle store data to matching loads.
module bigmem #(
   parameter int NPORT = 4,
   parameter int DW    = 32,
   parameter int AW    = 8
) (
   input  logic                       clk_t,
   input  logic                       rst_n,
   input  logic [NPORT-1:0][DW-1:0]   ALU_t,
   input  logic [NPORT-1:0][DW-1:0]   instr_t,
   input  logic [NPORT-1:0][DW-1:0]   reg2_t,
   input  logic [NPORT-1:0][1:0]      cmd_type_t,
   output logic [NPORT-1:0][DW-1:0]   ALU_o_t,
   output logic [NPORT-1:0][DW-1:0]   IR_t,
   output logic [NPORT-1:0][DW-1:0]   LMD_t
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      CMD_ALU    = 2'b00,
      CMD_LOAD   = 2'b01,
      CMD_STORE  = 2'b10,
      CMD_BUBBLE = 2'b11
   } cmd_e;

   logic [DW-1:0]              mem_q [DEPTH];
   logic [DW-1:0]              mem_d [DEPTH];
   logic [AW-1:0]              addr  [NPORT];
   logic [NPORT-1:0][DW-1:0]   alu_q, alu_d;
   logic [NPORT-1:0][DW-1:0]   ir_q, ir_d;
   logic [NPORT-1:0][DW-1:0]   lmd_q, lmd_d;

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         addr[p] = ALU_t[p][AW+1:2];
      end
   end

   // Stores applied in ascending port order, so the highest port wins a collision.
   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < NPORT; p++) begin
         if (cmd_type_t[p] == CMD_STORE) begin
            mem_d[addr[p]] = reg2_t[p];
         end
      end
   end

   always_comb begin
      alu_d = '0;
      ir_d  = '0;
      lmd_d = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (cmd_type_t[p] != CMD_BUBBLE) begin
            alu_d[p] = ALU_t[p];
            ir_d[p]  = instr_t[p];
         end
         if (cmd_type_t[p] == CMD_LOAD) begin
`ifdef BIGMEM_BYPASS_EN
            lmd_d[p] = mem_d[addr[p]];
`else
            lmd_d[p] = mem_q[addr[p]];
`endif
         end
      end
   end

   always_ff @(posedge clk_t or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         alu_q <= '0;
         ir_q  <= '0;
         lmd_q <= '0;
      end else begin
         mem_q <= mem_d;
         alu_q <= alu_d;
         ir_q  <= ir_d;
         lmd_q <= lmd_d;
      end
   end

   assign ALU_o_t = alu_q;
   assign IR_t    = ir_q;
   assign LMD_t   = lmd_q;

endmodule

// File: tb/tb_bigmem.sv
// Randomized and directed bench for bigmem against a behavioural memory model.
module tb_bigmem;

   localparam int NP = 4;

   logic                  clk_t = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NP-1:0][31:0]   alu_t, instr_t, reg2_t;
   logic [NP-1:0][1:0]    cmd_t;
   logic [NP-1:0][31:0]   alu_o, ir_o, lmd_o;

   logic [31:0] ref_mem [256];
   int vec_cnt = 0;
   int err_cnt = 0;

   bigmem dut (
      .clk_t      (clk_t),
      .rst_n      (rst_n),
      .ALU_t      (alu_t),
      .instr_t    (instr_t),
      .reg2_t     (reg2_t),
      .cmd_type_t (cmd_t),
      .ALU_o_t    (alu_o),
      .IR_t       (ir_o),
      .LMD_t      (lmd_o)
   );

   always #5 clk_t = ~clk_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] waddr(input logic [31:0] a);
      return a[9:2];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
   endtask

   task automatic all_bubble();
      for (int p = 0; p < NP; p++) begin
         cmd_t[p]   = 2'b11;
         alu_t[p]   = $urandom();
         instr_t[p] = $urandom();
         reg2_t[p]  = $urandom();
      end
   endtask

   task automatic set_port(input int p, input logic [1:0] c, input logic [31:0] a,
                           input logic [31:0] ins, input logic [31:0] d);
      cmd_t[p]   = c;
      alu_t[p]   = a;
      instr_t[p] = ins;
      reg2_t[p]  = d;
   endtask

   task automatic check_zero(input string tag);
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s_alu%0d", tag, p), alu_o[p], 32'h0);
         check($sformatf("%s_ir%0d", tag, p), ir_o[p], 32'h0);
         check($sformatf("%s_lmd%0d", tag, p), lmd_o[p], 32'h0);
      end
   endtask

   // Compute expectations from the model, clock once, compare every output.
   task automatic step(input string tag);
      logic [31:0] e_alu [NP];
      logic [31:0] e_ir  [NP];
      logic [31:0] e_lmd [NP];
      for (int p = 0; p < NP; p++) begin
         e_alu[p] = 32'h0;
         e_ir[p]  = 32'h0;
         e_lmd[p] = 32'h0;
         if (cmd_t[p] != 2'b11) begin
            e_alu[p] = alu_t[p];
            e_ir[p]  = instr_t[p];
         end
         if (cmd_t[p] == 2'b01) begin
            e_lmd[p] = ref_mem[waddr(alu_t[p])];
`ifdef BIGMEM_BYPASS_EN
            for (int q = 0; q < NP; q++) begin
               if (cmd_t[q] == 2'b10 && waddr(alu_t[q]) == waddr(alu_t[p])) e_lmd[p] = reg2_t[q];
            end
`endif
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (cmd_t[p] == 2'b10) ref_mem[waddr(alu_t[p])] = reg2_t[p];
      end
      @(posedge clk_t);
      #1;
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s_alu%0d", tag, p), alu_o[p], e_alu[p]);
         check($sformatf("%s_ir%0d", tag, p), ir_o[p], e_ir[p]);
         check($sformatf("%s_lmd%0d", tag, p), lmd_o[p], e_lmd[p]);
      end
   endtask

   initial begin
      clear_model();
      all_bubble();
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk_t);
      #1;
      rst_n = 1'b1;

      all_bubble();
      step("bubble");
      check_zero("bubble_direct");

      for (int p = 0; p < NP; p++) set_port(p, 2'b01, $urandom(), $urandom(), $urandom());
      step("load_init");
      for (int p = 0; p < NP; p++) check($sformatf("init_lmd%0d", p), lmd_o[p], 32'h0);

      all_bubble();
      set_port(0, 2'b10, 32'h10, 32'hAAAA0001, 32'hDEADBEEF);
      step("st10");
      all_bubble();
      set_port(2, 2'b01, 32'h10, 32'h12340002, 32'h0);
      step("ld10");
      check("ld10_lmd_direct", lmd_o[2], 32'hDEADBEEF);
      check("ld10_alu_direct", alu_o[2], 32'h10);
      check("ld10_ir_direct", ir_o[2], 32'h12340002);

      all_bubble();
      set_port(1, 2'b10, 32'h20, 32'h1, 32'h11111111);
      set_port(3, 2'b10, 32'h20, 32'h3, 32'h33333333);
      step("st20");
      all_bubble();
      set_port(0, 2'b01, 32'h20, 32'h5, 32'h0);
      step("ld20");
      check("collide_direct", lmd_o[0], 32'h33333333);

      all_bubble();
      set_port(0, 2'b10, 32'h40, 32'h6, 32'hA5A5A5A5);
      set_port(1, 2'b01, 32'h40, 32'h7, 32'h0);
      step("same_cyc");
`ifdef BIGMEM_BYPASS_EN
      check("bypass_direct", lmd_o[1], 32'hA5A5A5A5);
`else
      check("rbw_direct", lmd_o[1], 32'h0);
`endif

      all_bubble();
      set_port(2, 2'b10, 32'h400, 32'h8, 32'h12345678);
      step("st_wrap");
      all_bubble();
      set_port(3, 2'b01, 32'h000, 32'h9, 32'h0);
      set_port(1, 2'b00, 32'h7, 32'hA, 32'hFFFFFFFF);
      step("ld_wrap");
      check("wrap_direct", lmd_o[3], 32'h12345678);
      check("alu_direct", alu_o[1], 32'h7);
      check("alu_lmd_direct", lmd_o[1], 32'h0);

      for (int n = 0; n < 300; n++) begin
         for (int p = 0; p < NP; p++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[9:2] = 8'($urandom_range(0, 7));
            set_port(p, 2'($urandom_range(0, 3)), a, $urandom(), $urandom());
         end
         step("rand");
      end

      all_bubble();
      set_port(0, 2'b10, 32'h10, 32'hB, 32'hCAFEF00D);
      set_port(1, 2'b00, 32'h55, 32'hC, 32'h0);
      step("pre_rst");
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      clear_model();
      #2;
      rst_n = 1'b1;
      all_bubble();
      set_port(0, 2'b01, 32'h10, 32'hD, 32'h0);
      step("post_rst");
      check("post_rst_direct", lmd_o[0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
